// File: rtl/rvv_backend_rt_vrf_wb_pkg.sv
// Shared write-back queue types and constants: the retire-to-VRF payload
// plus the queue depth and the pointer/count widths derived from it.
package rvv_backend_rt_vrf_wb_pkg;

  localparam int VLEN                = 128;
  localparam int VLENB               = VLEN / 8;
  localparam int REGFILE_INDEX_WIDTH = 5;

  localparam int NUM_RT_UOP          = 4;
  localparam int WB_QUEUE_DEPTH      = 8;
  localparam int RT_WB_PTR_WIDTH     = $clog2(WB_QUEUE_DEPTH);
  localparam int RT_WB_CNT_WIDTH     = RT_WB_PTR_WIDTH + 1;

  typedef struct packed {
    logic [REGFILE_INDEX_WIDTH-1:0] rt_index;
    logic [VLEN-1:0]                rt_data;
    logic [VLENB-1:0]               rt_strobe;
  } RT2VRF_t;

  typedef logic [RT_WB_PTR_WIDTH-1:0] wb_ptr_t;
  typedef logic [RT_WB_CNT_WIDTH-1:0] wb_cnt_t;

endpackage

// File: rtl/rvv_backend_rt_wb_issue_sel.sv
// Picks which window entries can be written to the VRF this cycle.
// Issue is strictly in order and stops at the first entry whose register
// index already appears earlier in the window, so no two lanes ever carry
// the same index (the VRF would OR them together).
module rvv_backend_rt_wb_issue_sel
  import rvv_backend_rt_vrf_wb_pkg::*;
(
  input  logic [REGFILE_INDEX_WIDTH-1:0] win_index_i [NUM_RT_UOP],
  input  wb_cnt_t                        count_i,
  output logic [NUM_RT_UOP-1:0]          issue_o,
  output wb_cnt_t                        pop_cnt_o
);

  logic stop;
  logic conflict;

  // Walk the window lane by lane; once a lane is blocked all later lanes are too
  always_comb begin
    issue_o   = '0;
    pop_cnt_o = '0;
    stop      = 1'b0;
    conflict  = 1'b0;
    for (int j = 0; j < NUM_RT_UOP; j++) begin
      conflict = 1'b0;
      for (int m = 0; m < j; m++) begin
        if (win_index_i[m] == win_index_i[j]) begin
          conflict = 1'b1;
        end
      end
      if (stop || (j >= int'(count_i)) || conflict) begin
        stop = 1'b1;
      end else begin
        issue_o[j] = 1'b1;
        pop_cnt_o  = pop_cnt_o + wb_cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/rvv_backend_rt_vrf_wb.sv
// Retire-side write-back queue. Buffers retired uops from the ROB in order,
// drains them to the VRF write ports without same-index collisions, and
// reports which vector registers still have a write outstanding.
module rvv_backend_rt_vrf_wb
  import rvv_backend_rt_vrf_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_RT_UOP-1:0] rob2rt_valid,
  input  RT2VRF_t               rob2rt_data [NUM_RT_UOP],
  output logic [NUM_RT_UOP-1:0] rt2rob_ready,
  output logic [NUM_RT_UOP-1:0] rt2vrf_wr_valid,
  output RT2VRF_t               rt2vrf_wr_data [NUM_RT_UOP],
  output logic [31:0]           rt2dp_pending,
  output logic                  rt_empty
);

  RT2VRF_t mem_q [WB_QUEUE_DEPTH];

  wb_ptr_t wr_ptr_q, wr_ptr_d;
  wb_ptr_t rd_ptr_q, rd_ptr_d;
  wb_cnt_t count_q, count_d;
  wb_cnt_t push_cnt, pop_cnt;
  wb_ptr_t offset;

  logic [NUM_RT_UOP-1:0]          accept;
  logic [NUM_RT_UOP-1:0]          issue;
  logic [NUM_RT_UOP-1:0]          valid_plus1;
  logic                           dup_issue;
  RT2VRF_t                        win [NUM_RT_UOP];
  logic [REGFILE_INDEX_WIDTH-1:0] win_index [NUM_RT_UOP];

  // Lane i is ready when at least i+1 slots are free; same-cycle pops are not counted
  always_comb begin
    rt2rob_ready = '0;
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      rt2rob_ready[i] = ((WB_QUEUE_DEPTH - int'(count_q)) > i);
    end
  end

  assign accept = rob2rt_valid & rt2rob_ready;

  // Number of lanes accepted this cycle (lanes are contiguous from lane 0)
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      push_cnt = push_cnt + wb_cnt_t'(accept[i]);
    end
  end

  // Issue window: the next NUM_RT_UOP entries starting at the read pointer
  always_comb begin
    for (int j = 0; j < NUM_RT_UOP; j++) begin
      win[j]       = mem_q[rd_ptr_q + wb_ptr_t'(j)];
      win_index[j] = win[j].rt_index;
    end
  end

  rvv_backend_rt_wb_issue_sel u_issue_sel (
    .win_index_i (win_index),
    .count_i     (count_q),
    .issue_o     (issue),
    .pop_cnt_o   (pop_cnt)
  );

  assign rt2vrf_wr_valid = issue;
  assign rt_empty        = (count_q == '0);

  // Non-issued lanes drive an all-zero payload
  always_comb begin
    for (int j = 0; j < NUM_RT_UOP; j++) begin
      rt2vrf_wr_data[j] = issue[j] ? win[j] : '0;
    end
  end

  // Pending mask covers every occupied slot, including ones issuing this cycle
  always_comb begin
    rt2dp_pending = '0;
    offset        = '0;
    for (int e = 0; e < WB_QUEUE_DEPTH; e++) begin
      offset = wb_ptr_t'(e) - rd_ptr_q;
      if ({1'b0, offset} < count_q) begin
        rt2dp_pending[mem_q[e].rt_index] = 1'b1;
      end
    end
  end

  assign wr_ptr_d = wr_ptr_q + wb_ptr_t'(push_cnt);
  assign rd_ptr_d = rd_ptr_q + wb_ptr_t'(pop_cnt);
  assign count_d  = count_q + push_cnt - pop_cnt;

  // Queue pointers and occupancy; reset discards all buffered entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; occupancy alone decides validity, so no reset is needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      if (accept[i]) begin
        mem_q[wr_ptr_q + wb_ptr_t'(i)] <= rob2rt_data[i];
      end
    end
  end

  // Helper terms for the protocol and ordering checks below
  always_comb begin
    valid_plus1 = rob2rt_valid + {{(NUM_RT_UOP-1){1'b0}}, 1'b1};
    dup_issue   = 1'b0;
    for (int j = 0; j < NUM_RT_UOP; j++) begin
      for (int m = 0; m < j; m++) begin
        if (issue[j] && issue[m] && (win[j].rt_index == win[m].rt_index)) begin
          dup_issue = 1'b1;
        end
      end
    end
  end

  a_valid_contiguous: assert property (@(posedge clk) disable iff (rst)
    ((rob2rt_valid & valid_plus1) == '0));

  a_no_dup_issue: assert property (@(posedge clk) disable iff (rst)
    !dup_issue);

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    (count_q <= wb_cnt_t'(WB_QUEUE_DEPTH)));

endmodule

// File: tb/tb_rvv_backend_rt_vrf_wb.sv
// Directed bench for the retire write-back queue: reset values, single and
// multi-lane pushes, same-index serialisation, near-full backpressure,
// mid-flight reset, and a steady 2-in/2-out stream.
module tb_rvv_backend_rt_vrf_wb;
  import rvv_backend_rt_vrf_wb_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [NUM_RT_UOP-1:0] rob2rt_valid;
  RT2VRF_t               rob2rt_data [NUM_RT_UOP];
  logic [NUM_RT_UOP-1:0] rt2rob_ready;
  logic [NUM_RT_UOP-1:0] rt2vrf_wr_valid;
  RT2VRF_t               rt2vrf_wr_data [NUM_RT_UOP];
  logic [31:0]           rt2dp_pending;
  logic                  rt_empty;

  int testCount = 0;
  int failCount = 0;

  rvv_backend_rt_vrf_wb dut (
    .clk             (clk),
    .rst             (rst),
    .rob2rt_valid    (rob2rt_valid),
    .rob2rt_data     (rob2rt_data),
    .rt2rob_ready    (rt2rob_ready),
    .rt2vrf_wr_valid (rt2vrf_wr_valid),
    .rt2vrf_wr_data  (rt2vrf_wr_data),
    .rt2dp_pending   (rt2dp_pending),
    .rt_empty        (rt_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane-tagged payload: data byte A5/B6/C7/D8, strobe shrinks per lane, lane 3 all-zero
  function automatic RT2VRF_t mkEntry(input int idx, input int lane);
    RT2VRF_t    e;
    logic [7:0] b;
    b           = 8'(8'hA5 + 8'h11 * lane);
    e.rt_index  = REGFILE_INDEX_WIDTH'(idx);
    e.rt_data   = {16{b}};
    e.rt_strobe = (lane == 3) ? '0 : (16'hFFFF >> lane);
    return e;
  endfunction

  task automatic applyStimulus(input logic [3:0] v, input int i0, input int i1,
                               input int i2, input int i3);
    rob2rt_valid   = v;
    rob2rt_data[0] = mkEntry(i0, 0);
    rob2rt_data[1] = mkEntry(i1, 1);
    rob2rt_data[2] = mkEntry(i2, 2);
    rob2rt_data[3] = mkEntry(i3, 3);
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    #2;
    checkOutput("rst_wr_valid", rt2vrf_wr_valid, 4'b0000);
    checkOutput("rst_pending",  rt2dp_pending,   32'h0);
    checkOutput("rst_empty",    rt_empty,        1'b1);
    checkOutput("rst_ready",    rt2rob_ready,    4'b1111);

    @(posedge clk);
    #1;
    rst = 1'b0;
    tick;
    checkOutput("idle_wr_valid", rt2vrf_wr_valid, 4'b0000);
    checkOutput("idle_pending",  rt2dp_pending,   32'h0);
    checkOutput("idle_empty",    rt_empty,        1'b1);
    checkOutput("idle_ready",    rt2rob_ready,    4'b1111);

    // Single push of v3 on lane 0
    applyStimulus(4'b0001, 3, 0, 0, 0);
    tick;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    checkOutput("one_wr_valid", rt2vrf_wr_valid,   4'b0001);
    checkOutput("one_data0",    rt2vrf_wr_data[0], mkEntry(3, 0));
    checkOutput("one_data1",    rt2vrf_wr_data[1], 256'h0);
    checkOutput("one_pending",  rt2dp_pending,     32'h0000_0008);
    checkOutput("one_empty",    rt_empty,          1'b0);
    tick;
    checkOutput("one_pend_clr", rt2dp_pending,   32'h0);
    checkOutput("one_empty2",   rt_empty,        1'b1);
    checkOutput("one_wr_idle",  rt2vrf_wr_valid, 4'b0000);

    // Four lanes {1,2,1,4}: the repeated v1 splits the drain into two cycles
    applyStimulus(4'b1111, 1, 2, 1, 4);
    tick;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    checkOutput("dup_c1_valid", rt2vrf_wr_valid,   4'b0011);
    checkOutput("dup_c1_data0", rt2vrf_wr_data[0], mkEntry(1, 0));
    checkOutput("dup_c1_data1", rt2vrf_wr_data[1], mkEntry(2, 1));
    checkOutput("dup_c1_data2", rt2vrf_wr_data[2], 256'h0);
    checkOutput("dup_c1_pend",  rt2dp_pending,     32'h0000_0016);
    checkOutput("dup_c1_ready", rt2rob_ready,      4'b1111);
    tick;
    checkOutput("dup_c2_valid", rt2vrf_wr_valid,   4'b0011);
    checkOutput("dup_c2_data0", rt2vrf_wr_data[0], mkEntry(1, 2));
    checkOutput("dup_c2_data1", rt2vrf_wr_data[1], mkEntry(4, 3));
    checkOutput("dup_c2_pend",  rt2dp_pending,     32'h0000_0012);
    tick;
    checkOutput("dup_empty", rt_empty, 1'b1);

    // All-v9 bursts drain one per cycle, so occupancy climbs to 7 and ready shrinks
    applyStimulus(4'b1111, 9, 9, 9, 9);
    tick;
    checkOutput("fill_b_valid", rt2vrf_wr_valid,   4'b0001);
    checkOutput("fill_b_ready", rt2rob_ready,      4'b1111);
    checkOutput("fill_b_data0", rt2vrf_wr_data[0], mkEntry(9, 0));
    applyStimulus(4'b1111, 9, 9, 9, 9);
    tick;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    checkOutput("fill_c_ready", rt2rob_ready,      4'b0001);
    checkOutput("fill_c_valid", rt2vrf_wr_valid,   4'b0001);
    checkOutput("fill_c_data0", rt2vrf_wr_data[0], mkEntry(9, 1));
    checkOutput("fill_c_pend",  rt2dp_pending,     32'h0000_0200);
    tick;
    checkOutput("fill_d_ready", rt2rob_ready,      4'b0011);
    checkOutput("fill_d_data0", rt2vrf_wr_data[0], mkEntry(9, 2));
    tick;
    checkOutput("fill_e_ready", rt2rob_ready,      4'b0111);
    checkOutput("fill_e_empty", rt_empty,          1'b0);

    // Reset with five entries queued: outputs clear at once and nothing drains afterwards
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid",   rt2vrf_wr_valid, 4'b0000);
    checkOutput("mid_rst_pending", rt2dp_pending,   32'h0);
    checkOutput("mid_rst_empty",   rt_empty,        1'b1);
    checkOutput("mid_rst_ready",   rt2rob_ready,    4'b1111);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick;
      checkOutput("post_rst_valid", rt2vrf_wr_valid, 4'b0000);
      checkOutput("post_rst_empty", rt_empty,        1'b1);
    end

    // Steady stream: two distinct indices in, the previous pair out, every cycle
    applyStimulus(4'b0011, 0, 1, 0, 0);
    for (int c = 0; c < 16; c++) begin
      tick;
      if (c < 15) begin
        applyStimulus(4'b0011, 2 * (c + 1), 2 * (c + 1) + 1, 0, 0);
      end else begin
        applyStimulus(4'b0000, 0, 0, 0, 0);
      end
      checkOutput("ss_valid", rt2vrf_wr_valid, 4'b0011);
      checkOutput("ss_idx0",  rt2vrf_wr_data[0].rt_index, 2 * c);
      checkOutput("ss_data1", rt2vrf_wr_data[1], mkEntry(2 * c + 1, 1));
      checkOutput("ss_pend",  rt2dp_pending,
                  (32'd1 << (2 * c)) | (32'd1 << (2 * c + 1)));
      checkOutput("ss_ready", rt2rob_ready, 4'b1111);
    end
    tick;
    checkOutput("ss_drain_empty", rt_empty,        1'b1);
    checkOutput("ss_drain_valid", rt2vrf_wr_valid, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
